// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers each fetched word into a one-entry slot,
// stops on the halt word or an out-of-range fetch. Optional counters under FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter int unsigned IMEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        slot_free;
    logic        out_of_range;
    logic        load;
    logic [31:0] redirect_target;

    assign slot_free       = !valid_q || instr_ready;
    assign out_of_range    = (pc_q >> 2) >= 32'(IMEM_WORDS);
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        load       = 1'b0;
        unique case (state_q)
            StRun: begin
                if (redirect_valid) begin
                    // The word addressed this cycle belongs to the squashed path.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    if (out_of_range) begin
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                        state_d = StHalt;
                    end else if (imem_data == HALT_WORD) begin
                        valid_d = 1'b0;
                        state_d = StDrain;
                    end else begin
                        load       = 1'b1;
                        instr_d    = imem_data;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 32'd4;
                    end
                end
            end
            StDrain: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = StRun;
                end else begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == StHalt);
    assign fault       = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;
    logic        stall_cycle;

    assign stall_cycle = (state_q == StRun) && valid_q && !instr_ready;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (load && fetched_q != 32'hFFFF_FFFF) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (stall_cycle && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule
